bmm150_ctrl: RTL and testbench
==============================

# bmm150_ctrl

Sequencer for the BMM150 SPI master. After `run` is asserted it powers up the sensor, checks the chip ID, programs normal mode at a configurable output data rate, then reads the eight data registers (0x42–0x49) in a periodic loop. Each loop publishes assembled X/Y/Z/RHALL words with a one-cycle valid strobe. It sits between the SPI master and the user or display logic, and is the only driver of the master's control interface.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency, used only for documentation and derived defaults.
- `POWERUP_CYC`, 150_000: cycles to wait after the power-control write (3 ms at 50 MHz).
- `SAMPLE_CYC`, 5_000_000: burst period in cycles (10 Hz).
- `TIMEOUT_CYC`, 10_000: maximum cycles from `spi_start` to `spi_done` rising.
- `ODR`, 3'b000: data-rate field written to reg 0x4C[5:3].
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: level; high starts and keeps the controller running.
- `spi_enable` output 1: drives the master's `enable`.
- `spi_start` output 1: one-cycle transaction start pulse.
- `spi_rw` output 1: 1 = read, 0 = write.
- `spi_reg_addr` output 7: register address.
- `spi_tx_data` output 8: write data (0x00 on reads).
- `spi_rx_data` input 8, `spi_busy` input 1, `spi_done` input 1: from the master.
- `mag_x` output 13, `mag_y` output 13: signed samples.
- `mag_z` output 15: signed sample.
- `rhall` output 14: unsigned sample.
- `sample_valid` output 1: one-cycle strobe; the sample outputs are valid on that cycle.
- `init_done` output 1: high once the mode write has completed.
- `err` output 1: sticky error flag.
- `err_code` output 2: 01 = chip-ID mismatch, 10 = timeout.

## Operation
- Main FSM states: IDLE → PWR_WR → PWR_WAIT → ID_RD → MODE_WR → RUN_WAIT → BURST (8 reads) → PUBLISH → RUN_WAIT …; any state can go to ERROR.
- PWR_WR: write 0x4B = 0x01. PWR_WAIT then counts `POWERUP_CYC` cycles.
- ID_RD: read 0x40. If the byte ≠ 0x32, go to ERROR with code 01.
- MODE_WR: write 0x4C = {2'b00, ODR, 3'b000}. On completion `init_done` goes high.
- BURST: reads addresses 0x42..0x49 in ascending order, one transaction each, storing bytes b0..b7.
- PUBLISH:
  - `mag_x` = {b1, b0[7:3]}
  - `mag_y` = {b3, b2[7:3]}
  - `mag_z` = {b5, b4[7:1]}
  - `rhall` = {b7, b6[7:2]}
  - Pulse `sample_valid` for one cycle; return to RUN_WAIT.
- Period timer: reloads to `SAMPLE_CYC`-1 on BURST entry and decrements to 0. RUN_WAIT leaves when the timer is 0. If a burst lasts longer than the period, the next burst starts on the cycle after PUBLISH.
- Transaction sub-FSM: ISSUE → WAIT_DONE → WAIT_IDLE.
  - ISSUE asserts `spi_start` for exactly one cycle, only when `spi_busy`=0.
  - WAIT_DONE completes on a `spi_done` rising edge (done=1 and previous done=0). The read byte is captured on that cycle.
  - WAIT_IDLE holds until `spi_busy`=0, then returns control to the main FSM.
- `spi_rw`, `spi_reg_addr` and `spi_tx_data` stay stable from ISSUE through WAIT_IDLE exit.
- Timeout counter runs in WAIT_DONE. Reaching `TIMEOUT_CYC` goes to ERROR with code 10.
- ERROR: `err`=1 and `err_code` are held; no further starts are issued.
- `run` falling:
  - In IDLE, ERROR, PWR_WAIT or RUN_WAIT: go to IDLE on the next cycle.
  - Otherwise: go to IDLE after the current transaction reaches WAIT_IDLE exit.
  - Entering IDLE clears `init_done`, `err` and `err_code`. Raising `run` again restarts from PWR_WR.
- `spi_enable`=1 whenever the state is not IDLE and not ERROR.

## Timing
- Reset values: every output is 0 (`spi_reg_addr`=0, `spi_tx_data`=0, samples=0). FSM state is IDLE; all counters are 0.
- `run` rising to first `spi_start`: 2 cycles (IDLE→PWR_WR, then ISSUE).
- Byte capture to next `spi_start`: at least 2 cycles (WAIT_IDLE, then ISSUE).
- `sample_valid`: high on the cycle after the 8th byte's WAIT_IDLE exit. Outputs hold until the next PUBLISH.
- `err`: rises on the cycle after the detecting condition.
- `rst` takes priority over all other inputs on every cycle, including mid-transaction. `spi_enable` drops to 0 on the following cycle, which aborts the master.
- `spi_done` rising while not in WAIT_DONE is ignored.

## Configuration
- `BMM150_DRDY_CHECK_EN` defined: PUBLISH pulses `sample_valid` only when b6[0] (DRDY) = 1. Otherwise the outputs keep their old values and the FSM returns to RUN_WAIT.
- `BMM150_DRDY_CHECK_EN` undefined: every completed burst publishes regardless of b6[0].

## Test plan
- Slave model returns ID 0x32, `ODR`=3'b101 → write sequence is 0x4B←0x01, then 0x4C←0x28; `init_done`=1 after the 0x4C write.
- ID model returns 0x31 → `err`=1, `err_code`=01, no further `spi_start`, `init_done`=0.
- Data regs 0x42..0x49 = F8,7F,08,80,02,00,FD,FF → `mag_x`=0x0FFF, `mag_y`=0x1001, `mag_z`=0x0001, `rhall`=0x3FFF, with one-cycle `sample_valid`.
- Slave stalls (done never rises) during a burst, `TIMEOUT_CYC`=100 → `err_code`=10 exactly 101 cycles after `spi_start`.
- `SAMPLE_CYC`=1000 → consecutive bursts start 1000 cycles apart. Drop `run` mid-burst → current read completes, IDLE, flags cleared; `rst` mid-read → all outputs 0 next cycle.
- With `BMM150_DRDY_CHECK_EN`, b6=0xFC → no `sample_valid` and outputs unchanged; b6=0xFD → `sample_valid` pulses.

Source files
------------

// File: rtl/bmm150_ctrl.sv
// bmm150_ctrl: sequencer for the BMM150 SPI master.
// Powers the sensor up, checks the chip ID, programs normal mode, then reads
// registers 0x42..0x49 every SAMPLE_CYC cycles and publishes X/Y/Z/RHALL.
// Optional feature macro: BMM150_DRDY_CHECK_EN. When it is defined, a burst is
// published only if the DRDY bit (b6[0]) is set.
module bmm150_ctrl #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned POWERUP_CYC = CLK_HZ / 1000 * 3,
    parameter int unsigned SAMPLE_CYC  = CLK_HZ / 10,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / 5000,
    parameter logic [2:0]  ODR         = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        spi_enable,
    output logic        spi_start,
    output logic        spi_rw,
    output logic [6:0]  spi_reg_addr,
    output logic [7:0]  spi_tx_data,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_busy,
    input  logic        spi_done,
    output logic [12:0] mag_x,
    output logic [12:0] mag_y,
    output logic [14:0] mag_z,
    output logic [13:0] rhall,
    output logic        sample_valid,
    output logic        init_done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [3:0] {
        StIdle, StPwrWr, StPwrWait, StIdRd, StModeWr, StRunWait, StBurst, StPublish, StError
    } state_e;

    typedef enum logic [1:0] {TxIdle, TxIssue, TxWaitDone, TxWaitIdle} tx_e;

    state_e      state_q, state_d;
    tx_e         tx_q, tx_d;
    logic [2:0]  idx_q, idx_d;
    logic        done_q;
    logic [31:0] pw_cnt_q, pw_cnt_d;
    logic [31:0] per_cnt_q, per_cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  bytes_q [8];
    logic [7:0]  bytes_d [8];
    logic [12:0] mag_x_q, mag_x_d, mag_y_q, mag_y_d;
    logic [14:0] mag_z_q, mag_z_d;
    logic [13:0] rhall_q, rhall_d;
    logic        valid_q, valid_d;
    logic        init_q, init_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic done_rise, tx_end, tx_state, drdy_ok;

    assign done_rise = spi_done && !done_q;
    assign tx_end    = (tx_q == TxWaitIdle) && !spi_busy;
    assign tx_state  = (state_q == StPwrWr) || (state_q == StIdRd) ||
                       (state_q == StModeWr) || (state_q == StBurst);

`ifdef BMM150_DRDY_CHECK_EN
    assign drdy_ok = bytes_q[6][0];
`else
    assign drdy_ok = 1'b1;
`endif

    // Status and fraction bits that never reach an output.
    logic unused_lsbs;
    assign unused_lsbs = ^{bytes_q[0][2:0], bytes_q[2][2:0], bytes_q[4][0], bytes_q[6][1:0]};

    // Next-state logic for the main FSM, the transaction sub-FSM and all counters.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        idx_d     = idx_q;
        pw_cnt_d  = 32'd0;
        per_cnt_d = (per_cnt_q != 32'd0) ? per_cnt_q - 32'd1 : 32'd0;
        to_cnt_d  = (tx_q == TxWaitDone) ? to_cnt_q + 32'd1 : 32'd0;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        bytes_d   = bytes_q;
        mag_x_d   = mag_x_q;
        mag_y_d   = mag_y_q;
        mag_z_d   = mag_z_q;
        rhall_d   = rhall_q;
        valid_d   = 1'b0;
        init_d    = init_q;
        err_d     = err_q;
        code_d    = code_q;

        // Transaction sub-FSM; only leaves TxIdle inside a state that owns an access.
        if (tx_state) begin
            unique case (tx_q)
                TxIdle: begin
                    tx_d = TxIssue;
                    case (state_q)
                        StPwrWr: begin
                            rw_d = 1'b0; addr_d = 7'h4B; wdata_d = 8'h01;
                        end
                        StIdRd: begin
                            rw_d = 1'b1; addr_d = 7'h40; wdata_d = 8'h00;
                        end
                        StModeWr: begin
                            rw_d = 1'b0; addr_d = 7'h4C; wdata_d = {2'b00, ODR, 3'b000};
                        end
                        default: begin
                            rw_d = 1'b1; addr_d = 7'h42 + {4'd0, idx_q}; wdata_d = 8'h00;
                        end
                    endcase
                end
                TxIssue:    if (!spi_busy) tx_d = TxWaitDone;
                TxWaitDone: begin
                    if (done_rise) begin
                        tx_d = TxWaitIdle;
                        rx_d = spi_rx_data;
                        if (state_q == StBurst) bytes_d[idx_q] = spi_rx_data;
                    end
                end
                TxWaitIdle: if (!spi_busy) tx_d = TxIdle;
            endcase
        end

        unique case (state_q)
            StIdle:    if (run) state_d = StPwrWr;
            StPwrWr:   if (tx_end) state_d = run ? StPwrWait : StIdle;
            StPwrWait: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (pw_cnt_q + 32'd1 >= POWERUP_CYC) begin
                    state_d = StIdRd;
                end else begin
                    pw_cnt_d = pw_cnt_q + 32'd1;
                end
            end
            StIdRd: begin
                if (tx_end) begin
                    if (!run) begin
                        state_d = StIdle;
                    end else if (rx_q != 8'h32) begin
                        state_d = StError;
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                    end else begin
                        state_d = StModeWr;
                    end
                end
            end
            StModeWr: begin
                if (tx_end) begin
                    state_d = run ? StRunWait : StIdle;
                    init_d  = 1'b1;
                end
            end
            StRunWait: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (per_cnt_q == 32'd0) begin
                    state_d   = StBurst;
                    per_cnt_d = SAMPLE_CYC - 32'd1;
                    idx_d     = 3'd0;
                end
            end
            StBurst: begin
                if (tx_end) begin
                    if (!run) begin
                        state_d = StIdle;
                    end else if (idx_q == 3'd7) begin
                        state_d = StPublish;
                        if (drdy_ok) begin
                            valid_d = 1'b1;
                            mag_x_d = {bytes_q[1], bytes_q[0][7:3]};
                            mag_y_d = {bytes_q[3], bytes_q[2][7:3]};
                            mag_z_d = {bytes_q[5], bytes_q[4][7:1]};
                            rhall_d = {bytes_q[7], bytes_q[6][7:2]};
                        end
                    end else begin
                        // Chain straight into the next read without a setup cycle.
                        idx_d  = idx_q + 3'd1;
                        tx_d   = TxIssue;
                        addr_d = 7'h43 + {4'd0, idx_q};
                    end
                end
            end
            StPublish: state_d = run ? StRunWait : StIdle;
            StError:   if (!run) state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Nothing issued yet, so a dropped run can abandon the access at once.
        if (tx_state && (tx_q == TxIdle) && !run) state_d = StIdle;

        if ((tx_q == TxWaitDone) && !done_rise && (to_cnt_q + 32'd1 >= TIMEOUT_CYC)) begin
            state_d = StError;
            err_d   = 1'b1;
            code_d  = 2'b10;
        end

        if (state_d == StIdle) begin
            init_d = 1'b0;
            err_d  = 1'b0;
            code_d = 2'b00;
        end

        if (state_d != state_q) tx_d = TxIdle;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tx_q      <= TxIdle;
            idx_q     <= 3'd0;
            done_q    <= 1'b0;
            pw_cnt_q  <= 32'd0;
            per_cnt_q <= 32'd0;
            to_cnt_q  <= 32'd0;
            rw_q      <= 1'b0;
            addr_q    <= 7'd0;
            wdata_q   <= 8'd0;
            rx_q      <= 8'd0;
            bytes_q   <= '{default: 8'd0};
            mag_x_q   <= 13'd0;
            mag_y_q   <= 13'd0;
            mag_z_q   <= 15'd0;
            rhall_q   <= 14'd0;
            valid_q   <= 1'b0;
            init_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            idx_q     <= idx_d;
            done_q    <= spi_done;
            pw_cnt_q  <= pw_cnt_d;
            per_cnt_q <= per_cnt_d;
            to_cnt_q  <= to_cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            bytes_q   <= bytes_d;
            mag_x_q   <= mag_x_d;
            mag_y_q   <= mag_y_d;
            mag_z_q   <= mag_z_d;
            rhall_q   <= rhall_d;
            valid_q   <= valid_d;
            init_q    <= init_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign spi_enable   = (state_q != StIdle) && (state_q != StError);
    assign spi_start    = (tx_q == TxIssue) && !spi_busy;
    assign spi_rw       = rw_q;
    assign spi_reg_addr = addr_q;
    assign spi_tx_data  = wdata_q;
    assign mag_x        = mag_x_q;
    assign mag_y        = mag_y_q;
    assign mag_z        = mag_z_q;
    assign rhall        = rhall_q;
    assign sample_valid = valid_q;
    assign init_done    = init_q;
    assign err          = err_q;
    assign err_code     = code_q;

endmodule

// File: tb/tb_bmm150_ctrl.sv
// tb_bmm150_ctrl: directed bench for bmm150_ctrl with a behavioural SPI master/slave model.
module tb_bmm150_ctrl;

    logic        clk = 1'b0;
    logic        rst, run;
    logic        spi_enable, spi_start, spi_rw;
    logic [6:0]  spi_reg_addr;
    logic [7:0]  spi_tx_data, spi_rx_data;
    logic        spi_busy, spi_done;
    logic [12:0] mag_x, mag_y;
    logic [14:0] mag_z;
    logic [13:0] rhall;
    logic        sample_valid, init_done, err;
    logic [1:0]  err_code;

    bmm150_ctrl #(
        .POWERUP_CYC (20),
        .SAMPLE_CYC  (1000),
        .TIMEOUT_CYC (100),
        .ODR         (3'b101)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .spi_enable   (spi_enable),
        .spi_start    (spi_start),
        .spi_rw       (spi_rw),
        .spi_reg_addr (spi_reg_addr),
        .spi_tx_data  (spi_tx_data),
        .spi_rx_data  (spi_rx_data),
        .spi_busy     (spi_busy),
        .spi_done     (spi_done),
        .mag_x        (mag_x),
        .mag_y        (mag_y),
        .mag_z        (mag_z),
        .rhall        (rhall),
        .sample_valid (sample_valid),
        .init_done    (init_done),
        .err          (err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave contents and stall control, driven by the main sequence.
    logic [7:0] id_val;
    logic [7:0] regs [8];
    logic       stall;

    // Transaction log, written only by the model.
    logic       log_rw   [256];
    logic [6:0] log_addr [256];
    logic [7:0] log_data [256];
    logic       log_init [256];
    int         log_cyc  [256];
    int         b_cyc    [16];
    int n_start = 0, n_done = 0, n_valid = 0, n_double = 0, n_burst = 0;

    int n_pass = 0, n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] reg_val(input logic [6:0] a);
        if (a == 7'h40) return id_val;
        if (a >= 7'h42 && a <= 7'h49) return regs[int'(a) - 'h42];
        return 8'h00;
    endfunction

    task automatic set_regs(input logic [63:0] v);
        for (int i = 0; i < 8; i++) regs[i] = v[63 - 8 * i -: 8];
    endtask

    // sel: 0 starts, 1 valid pulses, 2 bursts, 3 init_done, 4 err, else enable low.
    task automatic wait_ev(input int sel, input int target, input int bound, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            #1;
            case (sel)
                0:       ok = (n_start >= target);
                1:       ok = (n_valid >= target);
                2:       ok = (n_burst >= target);
                3:       ok = (init_done == 1'b1);
                4:       ok = (err == 1'b1);
                default: ok = (spi_enable == 1'b0);
            endcase
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // Master model: latches start seen before an edge, busy for a few cycles,
    // then a one-cycle done with the read byte; aborts whenever enable is low.
    initial begin
        logic       st, en, prev_valid;
        logic [6:0] cur_addr;
        int         phase, lat;
        spi_busy = 1'b0; spi_done = 1'b0; spi_rx_data = 8'h00;
        phase = 0; lat = 0; prev_valid = 1'b0; cur_addr = 7'd0;
        forever begin
            @(negedge clk);
            st = spi_start;
            en = spi_enable;
            if (st && n_start < 256) begin
                log_rw[n_start]   = spi_rw;
                log_addr[n_start] = spi_reg_addr;
                log_data[n_start] = spi_tx_data;
                log_init[n_start] = init_done;
                log_cyc[n_start]  = cyc;
                if (spi_reg_addr == 7'h42 && n_burst < 16) begin
                    b_cyc[n_burst] = cyc;
                    n_burst++;
                end
                cur_addr = spi_reg_addr;
                n_start++;
            end
            if (sample_valid) begin
                n_valid++;
                if (prev_valid) n_double++;
            end
            prev_valid = sample_valid;
            @(posedge clk);
            #1;
            if (!en) begin
                spi_busy = 1'b0; spi_done = 1'b0; phase = 0;
            end else begin
                case (phase)
                    0: if (st) begin spi_busy = 1'b1; phase = 1; lat = 3; end
                    1: begin
                        if (lat > 1) lat--;
                        else if (!stall) begin
                            spi_done = 1'b1; spi_rx_data = reg_val(cur_addr);
                            phase = 2; n_done++;
                        end
                    end
                    default: begin spi_done = 1'b0; spi_busy = 1'b0; phase = 0; end
                endcase
            end
        end
    end

    initial begin
        int r_cyc, s0, d0, sc;
        rst = 1'b1; run = 1'b0; stall = 1'b0; id_val = 8'h32;
        set_regs(64'hF87F_0880_0200_FDFF);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {9'd0, spi_enable, spi_start, spi_rw, spi_reg_addr, spi_tx_data,
                             sample_valid, init_done, err, err_code}, 32'd0);
        check("reset_xy", {6'd0, mag_x, mag_y}, 32'd0);
        check("reset_zr", {3'd0, mag_z, rhall}, 32'd0);

        // Bring-up and first burst.
        @(posedge clk); #1; run = 1'b1; r_cyc = cyc;
        wait_ev(0, 1, 10, "first_start_seen");
        check("run_to_start", log_cyc[0] - r_cyc, 32'd2);
        wait_ev(3, 0, 500, "init_seen");
        check("pwr_wr", {16'd0, log_rw[0], log_addr[0], log_data[0]}, {16'd0, 1'b0, 7'h4B, 8'h01});
        check("id_rd", {24'd0, log_rw[1], log_addr[1]}, {24'd0, 1'b1, 7'h40});
        check("mode_wr", {16'd0, log_rw[2], log_addr[2], log_data[2]}, {16'd0, 1'b0, 7'h4C, 8'h28});
        check("init_low_before_mode", {31'd0, log_init[2]}, 32'd0);
        wait_ev(1, 1, 300, "valid1_seen");
        check("p1_mag_x", {19'd0, mag_x}, 32'h0FFF);
        check("p1_mag_y", {19'd0, mag_y}, 32'h1001);
        check("p1_mag_z", {17'd0, mag_z}, 32'h0001);
        check("p1_rhall", {18'd0, rhall}, 32'h3FFF);
        for (int i = 0; i < 8; i++)
            check("burst_addr", {24'd0, log_rw[3 + i], log_addr[3 + i]}, 32'hC2 + i);

        // Second burst, one period later, new data with DRDY set.
        set_regs(64'h0080_F87F_FFFF_0100);
        wait_ev(1, 2, 1500, "valid2_seen");
        check("p2_mag_x", {19'd0, mag_x}, 32'h1000);
        check("p2_mag_y", {19'd0, mag_y}, 32'h0FFF);
        check("p2_mag_z", {17'd0, mag_z}, 32'h7FFF);
        check("p2_rhall", {18'd0, rhall}, 32'h0000);
        check("burst_period", b_cyc[1] - b_cyc[0], 32'd1000);

        // Third burst with DRDY clear.
        set_regs(64'h1122_3344_5566_FC01);
        wait_ev(2, 3, 1500, "burst3_seen");
        repeat (100) @(negedge clk);
`ifdef BMM150_DRDY_CHECK_EN
        check("drdy_no_valid", n_valid, 32'd2);
        check("drdy_hold", {19'd0, mag_x}, 32'h1000);
`else
        check("nodrdy_valid", n_valid, 32'd3);
        check("nodrdy_mag_x", {19'd0, mag_x}, 32'h0442);
`endif
        check("valid_one_cycle", n_double, 32'd0);

        // Drop run while the first read of a burst is in flight.
        wait_ev(2, 4, 1200, "burst4_seen");
        @(posedge clk); #1; run = 1'b0; s0 = n_start; d0 = n_done;
        wait_ev(5, 0, 50, "idle_after_drop");
        check("drop_read_done", n_done - d0, 32'd1);
        check("drop_no_start", n_start - s0, 32'd0);
        check("drop_flags", {30'd0, init_done, err}, 32'd0);

        // Restart, then stall the first burst read until it times out.
        @(posedge clk); #1; run = 1'b1; s0 = n_start;
        wait_ev(0, s0 + 1, 10, "restart_seen");
        check("restart_pwr_wr", {16'd0, log_rw[s0], log_addr[s0], log_data[s0]},
              {16'd0, 1'b0, 7'h4B, 8'h01});
        wait_ev(3, 0, 500, "init2_seen");
        stall = 1'b1; s0 = n_start;
        wait_ev(0, s0 + 1, 1500, "stall_start_seen");
        sc = log_cyc[n_start - 1];
        wait_ev(4, 0, 300, "timeout_err_seen");
        check("timeout_code", {30'd0, err_code}, 32'd2);
        check("timeout_latency", cyc - sc, 32'd101);
        check("err_enable_low", {31'd0, spi_enable}, 32'd0);
        s0 = n_start;
        repeat (50) @(negedge clk);
        check("err_no_start", n_start - s0, 32'd0);
        @(posedge clk); #1; run = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);
        check("err_cleared", {29'd0, err, err_code}, 32'd0);

        // Wrong chip ID.
        id_val = 8'h31;
        @(posedge clk); #1; run = 1'b1;
        wait_ev(4, 0, 300, "id_err_seen");
        check("id_err_code", {30'd0, err_code}, 32'd1);
        check("id_err_init", {31'd0, init_done}, 32'd0);
        s0 = n_start;
        repeat (50) @(negedge clk);
        check("id_err_no_start", n_start - s0, 32'd0);
        @(posedge clk); #1; run = 1'b0;
        repeat (2) @(negedge clk);

        // Synchronous reset in the middle of the ID read.
        id_val = 8'h32;
        @(posedge clk); #1; run = 1'b1; s0 = n_start;
        wait_ev(0, s0 + 2, 200, "id2_start_seen");
        check("id2_addr", {25'd0, log_addr[n_start - 1]}, 32'h40);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {9'd0, spi_enable, spi_start, spi_rw, spi_reg_addr, spi_tx_data,
                           sample_valid, init_done, err, err_code}, 32'd0);
        check("rst_xy", {6'd0, mag_x, mag_y}, 32'd0);
        check("rst_zr", {3'd0, mag_z, rhall}, 32'd0);
        rst = 1'b0; run = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
